// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronised line, Prescale-x oversampling, 3-sample majority per bit.
// Strobes (Data_Valid / PAR_ERR / STP_ERR) are registered one cycle after the stop-bit decision.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  busy
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 3);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_nxt;
  logic                    rx_meta, rx_s;
  logic                    armed;
  logic [PRESC_W-1:0]      cfg_p;
  logic                    cfg_par_en, cfg_par_typ;
  logic [PRESC_W-1:0]      edge_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [2:0]              smp;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_bad;

  logic [PRESC_W-1:0]      half;
  logic                    wrap, decide, maj, start_det;

  assign half      = cfg_p >> 1;
  assign wrap      = (edge_cnt == cfg_p - PRESC_W'(1));
  assign decide    = (edge_cnt == half + PRESC_W'(2));
  assign maj       = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign start_det = armed && !rx_s;
  assign busy      = (state != IDLE);

  // Every non-IDLE state has an exit on wrap or decide, so illegal Prescale values cannot hang.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start_det) state_nxt = START;
      START: begin
        if (decide && maj) state_nxt = IDLE;
        else if (wrap)     state_nxt = DATA;
      end
      DATA:   if (wrap && bit_cnt == BIT_W'(DATA_WIDTH)) state_nxt = cfg_par_en ? PARITY : STOP;
      PARITY: if (wrap) state_nxt = STOP;
      STOP:   if (decide || wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      armed       <= 1'b0;
      cfg_p       <= '0;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      smp         <= '0;
      shreg       <= '0;
      par_bad     <= 1'b0;
      P_DATA      <= '0;
      Data_Valid  <= 1'b0;
      PAR_ERR     <= 1'b0;
      STP_ERR     <= 1'b0;
    end else begin
      rx_meta    <= RX_IN;
      rx_s       <= rx_meta;
      state      <= state_nxt;
      Data_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;

      if (state == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        par_bad  <= 1'b0;
        if (rx_s) armed <= 1'b1;
        if (start_det) begin
          cfg_p       <= Prescale;
          cfg_par_en  <= PAR_EN;
          cfg_par_typ <= PAR_TYP;
        end
      end else begin
        if (wrap) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + BIT_W'(1);
        end else begin
          edge_cnt <= edge_cnt + PRESC_W'(1);
        end

        if (edge_cnt == half - PRESC_W'(1)) smp[0] <= rx_s;
        if (edge_cnt == half)               smp[1] <= rx_s;
        if (edge_cnt == half + PRESC_W'(1)) smp[2] <= rx_s;

        if (decide) begin
          unique case (state)
            DATA:   shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
            PARITY: par_bad <= (maj != ((^shreg) ^ cfg_par_typ));
            STOP: begin
              // A low stop bit disarms IDLE until the line has been seen high again.
              armed   <= maj;
              PAR_ERR <= par_bad;
              STP_ERR <= !maj;
              if (maj && !par_bad) begin
                Data_Valid <= 1'b1;
                P_DATA     <= shreg;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver and companion to the UART transmitter. Recovers 8-bit frames from the serial line RX_IN: start bit, 8 data bits LSB first, optional parity, 1 stop bit.
- Line is oversampled at Prescale × baud on CLK. Each bit is decided by a 3-sample majority vote.
- Outputs go to the system-side FIFO/controller: parallel data, a one-cycle valid strobe, parity-error and stop-error strobes.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESC_W, 6, width of the Prescale input.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- RX_IN  input  1  serial line, idle high, asynchronous to CLK.
- PAR_EN  input  1  1 = parity bit present in frame.
- PAR_TYP  input  1  1 = odd parity, 0 = even parity.
- Prescale  input  PRESC_W  oversampling ratio; legal values are 8, 16, 32 only.
- P_DATA  output  DATA_WIDTH  last good received byte.
- Data_Valid  output  1  one-cycle pulse when P_DATA updates.
- PAR_ERR  output  1  one-cycle pulse on parity mismatch.
- STP_ERR  output  1  one-cycle pulse on stop bit sampled 0.
- busy  output  1  high while a frame is in progress (FSM not in IDLE).

Behaviour:
- Reset values:
  - P_DATA = 0; Data_Valid, PAR_ERR, STP_ERR, busy = 0.
  - FSM = IDLE; counters = 0; synchronizer flops = 1.
  - Reset mid-frame aborts the frame with no strobes.
- Synchronizer: RX_IN passes through a 2-flop synchronizer (rx_s). If RX_IN is first sampled low at edge E, the FSM leaves IDLE at edge T0 = E+2.
- Config latch: PAR_EN, PAR_TYP and Prescale (P) are latched at T0 and held constant for the whole frame.
- Counters:
  - edge_cnt runs 0..P-1 within each bit, then wraps.
  - bit_cnt is incremented at each wrap.
  - T0 is edge_cnt = 0 of the start bit (bit index 0).
- Sampling:
  - Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1.
  - Bit value = majority of the 3 samples, registered at edge_cnt = P/2+2 (the decision cycle).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: armed only after rx_s has been seen 1 for at least one cycle. Armed and rx_s = 0 -> START.
  - START: decision 1 -> glitch; go to IDLE with no strobes. Decision 0 -> DATA at end of bit.
  - DATA: shift decided bits in LSB first. After bit 8 ends -> PARITY if PAR_EN, else STOP.
  - PARITY: compare the decided bit with the computed parity. Even: parity bit = XOR of data. Odd: parity bit = inverted XOR. Store a mismatch flag. End of bit -> STOP.
  - STOP: at the decision cycle, transition to IDLE immediately (this allows back-to-back frames).
- Strobes at the STOP decision cycle (registered, asserted the following cycle, 1 cycle wide):
  - Stop = 1 and parity ok: Data_Valid = 1, P_DATA <= shift register.
  - Parity mismatch: PAR_ERR = 1.
  - Stop = 0: STP_ERR = 1.
  - Either error: no Data_Valid, P_DATA keeps its old value. Both errors may pulse together.
- Latency: let s = 9 without parity, 10 with parity. Data_Valid is high in cycle T0 + s·P + P/2 + 3.
  - Example: P = 8, no parity -> T0+79.
- busy: rises at T0, falls on the cycle IDLE is re-entered.
- After STP_ERR the line may still be low. IDLE does not restart until rx_s returns to 1 (break protection).
- Prescale outside {8, 16, 32} is unsupported. Behaviour is undefined but must not lock up; reset recovers.

Test Plan:
- P = 8, PAR_EN = 0, send 0xA5 at 8 CLK/bit -> Data_Valid pulse at T0+79, P_DATA = 0xA5, PAR_ERR = STP_ERR = 0, busy low afterwards.
- P = 16, PAR_EN = 1, PAR_TYP = 0, send 0x3C with parity bit 0 -> P_DATA = 0x3C, Data_Valid at T0+171. Same frame with parity bit 1 -> PAR_ERR pulse, no Data_Valid, P_DATA unchanged.
- P = 32, PAR_EN = 1, PAR_TYP = 1, send 0x00 with parity bit 1 and stop bit 0, then line high -> STP_ERR only, no Data_Valid. Next frame 0x81 is received correctly.
- P = 16, RX_IN low pulse of 3 CLK cycles -> START decision 1, return to IDLE, no strobes, busy high for < P cycles.
- P = 8, two frames 0x55 then 0xAA back-to-back with no idle gap -> two Data_Valid pulses 80 cycles apart, correct bytes.
- P = 16, assert RST during data bit 4, then send 0x7E -> all outputs 0 during reset, next Data_Valid carries 0x7E.
